// File: rtl/wbc_reqtrack.sv
// Per-port request tracker: one-outstanding "sent" flag plus the registered
// ACK/ERR/read-data return path for a single classic master.
module wbc_reqtrack #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          own,
  input  logic          cyc,
  input  logic          stb,
  input  logic          mstall,
  input  logic          mack,
  input  logic          merr,
  input  logic [DW-1:0] mdata,
  output logic          active,
  output logic          req,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] data
);

  logic sent;
  logic live;

  assign live   = own & cyc & stb;
  // A registered ERR suppresses the cycle so the slave sees the bus release.
  assign active = own & cyc & ~err;
  assign req    = live & ~sent & ~err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent <= 1'b0;
      ack  <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (~own | ~cyc | ~stb | ack | err)
        sent <= 1'b0;
      else if (req & ~mstall)
        sent <= 1'b1;
      ack <= live & mack & ~merr & ~ack & ~err;
      err <= live & merr & ~ack & ~err;
    end
  end

  // Read data carries no reset; it is only meaningful alongside ack.
  always_ff @(posedge clk) begin
    if (own & mack)
      data <= mdata;
  end

endmodule

// File: rtl/wbc2pipe_arbiter.sv
// Two WB classic masters sharing one WB pipelined slave: round-robin
// per-CYC ownership, one pipelined request per classic STB.
module wbc2pipe_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic [DW-1:0]   o_a_data,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic [DW-1:0]   o_b_data,
  output logic            o_b_err,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mstall,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_b, last_b_nxt;
  logic   a_req, b_req;
  logic   own_a, own_b;
  logic   a_active, b_active, a_issue, b_issue;

  assign a_req = i_a_cyc & i_a_stb;
  assign b_req = i_b_cyc & i_b_stb;
  assign own_a = (state == S_OWN_A);
  assign own_b = (state == S_OWN_B);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
    end
  end

  // Ownership always passes through IDLE, giving the slave one cycle with CYC low.
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    unique case (state)
      S_IDLE: begin
        if (a_req && (!b_req || last_b))
          state_nxt = S_OWN_A;
        else if (b_req)
          state_nxt = S_OWN_B;
      end
      S_OWN_A: begin
        if (!i_a_cyc) begin
          state_nxt  = S_IDLE;
          last_b_nxt = 1'b0;
        end
      end
      S_OWN_B: begin
        if (!i_b_cyc) begin
          state_nxt  = S_IDLE;
          last_b_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  wbc_reqtrack #(.DW(DW)) u_track_a (
    .clk    (i_clk),
    .rst    (i_reset),
    .own    (own_a),
    .cyc    (i_a_cyc),
    .stb    (i_a_stb),
    .mstall (i_mstall),
    .mack   (i_mack),
    .merr   (i_merr),
    .mdata  (i_mdata),
    .active (a_active),
    .req    (a_issue),
    .ack    (o_a_ack),
    .err    (o_a_err),
    .data   (o_a_data)
  );

  wbc_reqtrack #(.DW(DW)) u_track_b (
    .clk    (i_clk),
    .rst    (i_reset),
    .own    (own_b),
    .cyc    (i_b_cyc),
    .stb    (i_b_stb),
    .mstall (i_mstall),
    .mack   (i_mack),
    .merr   (i_merr),
    .mdata  (i_mdata),
    .active (b_active),
    .req    (b_issue),
    .ack    (o_b_ack),
    .err    (o_b_err),
    .data   (o_b_data)
  );

  assign o_mcyc  = a_active | b_active;
  assign o_mstb  = a_issue | b_issue;
  // Payload follows B only while B owns; otherwise A (don't-care when idle).
  assign o_mwe   = own_b ? i_b_we   : i_a_we;
  assign o_maddr = own_b ? i_b_addr : i_a_addr;
  assign o_mdata = own_b ? i_b_data : i_a_data;
  assign o_msel  = own_b ? i_b_sel  : i_a_sel;

endmodule

// File: tb/tb_wbc2pipe_arbiter.sv
// Directed table-driven bench for wbc2pipe_arbiter plus a hand-written
// reset-during-stall sequence.
module tb_wbc2pipe_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            a_cyc, a_stb, a_we;
  logic            b_cyc, b_stb, b_we;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_wdata, b_wdata;
  logic [DW/8-1:0] a_sel, b_sel;
  logic            a_ack, a_err, b_ack, b_err;
  logic [DW-1:0]   a_rdata, b_rdata;
  logic            mcyc, mstb, mwe;
  logic [AW-1:0]   maddr;
  logic [DW-1:0]   mdata_out;
  logic [DW/8-1:0] msel;
  logic            mstall, mack, merr;
  logic [DW-1:0]   mdata_in;

  wbc2pipe_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_a_cyc  (a_cyc),
    .i_a_stb  (a_stb),
    .i_a_we   (a_we),
    .i_a_addr (a_addr),
    .i_a_data (a_wdata),
    .i_a_sel  (a_sel),
    .o_a_ack  (a_ack),
    .o_a_data (a_rdata),
    .o_a_err  (a_err),
    .i_b_cyc  (b_cyc),
    .i_b_stb  (b_stb),
    .i_b_we   (b_we),
    .i_b_addr (b_addr),
    .i_b_data (b_wdata),
    .i_b_sel  (b_sel),
    .o_b_ack  (b_ack),
    .o_b_data (b_rdata),
    .o_b_err  (b_err),
    .o_mcyc   (mcyc),
    .o_mstb   (mstb),
    .o_mwe    (mwe),
    .o_maddr  (maddr),
    .o_mdata  (mdata_out),
    .o_msel   (msel),
    .i_mstall (mstall),
    .i_mack   (mack),
    .i_merr   (merr),
    .i_mdata  (mdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inb = {rst, a_cyc, a_stb, a_we, b_cyc, b_stb, b_we, mstall, mack, merr}
  // ex  = {mcyc, mstb, a_ack, a_err, b_ack, b_err}
  typedef struct {
    string       name;
    logic [9:0]  inb;
    logic [5:0]  ex;
    bit          own_b;
    logic [31:0] md;
    bit          chk_ad;
    logic [31:0] ad;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   passed;

  task automatic add(input string n, input logic [9:0] inb, input logic [5:0] ex,
                     input bit own_b, input logic [31:0] md, input bit chk_ad,
                     input logic [31:0] ad);
    vec_t v;
    v.name = n; v.inb = inb; v.ex = ex; v.own_b = own_b;
    v.md = md; v.chk_ad = chk_ad; v.ad = ad;
    vq.push_back(v);
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  initial begin
    vec_t v;
    total  = 0;
    passed = 0;
    rst = 1'b1;
    a_cyc = 0; a_stb = 0; a_we = 0; b_cyc = 0; b_stb = 0; b_we = 0;
    mstall = 0; mack = 0; merr = 0; mdata_in = '0;
    a_addr = 12'h010; a_wdata = 32'hA5A5_A5A5; a_sel = 4'h3;
    b_addr = 12'h0AB; b_wdata = 32'h1234_5678; b_sel = 4'hF;

    add("reset",  10'b1_000_000_000, 6'b000000, 0, 0, 0, 0);
    // A reads alone, slave acks one clock after the accepted strobe
    add("t1_c0",  10'b0_110_000_000, 6'b000000, 0, 0, 0, 0);
    add("t1_c1",  10'b0_110_000_000, 6'b110000, 0, 0, 0, 0);
    add("t1_c2",  10'b0_110_000_010, 6'b100000, 0, 32'hDEAD_BEEF, 0, 0);
    add("t1_c3",  10'b0_110_000_000, 6'b101000, 0, 0, 1, 32'hDEAD_BEEF);
    add("t1_c4",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t1_c5",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    // Tie after reset goes to A, one idle cycle, then B, next tie to A
    add("t2_rst", 10'b1_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c0",  10'b0_110_110_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c1",  10'b0_110_110_000, 6'b110000, 0, 0, 0, 0);
    add("t2_c2",  10'b0_110_110_010, 6'b100000, 0, 32'h0000_0001, 0, 0);
    add("t2_c3",  10'b0_110_110_000, 6'b101000, 0, 0, 1, 32'h0000_0001);
    add("t2_c4",  10'b0_000_110_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c5",  10'b0_000_110_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c6",  10'b0_000_110_000, 6'b110000, 1, 0, 0, 0);
    add("t2_c7",  10'b0_000_110_010, 6'b100000, 1, 0, 0, 0);
    add("t2_c8",  10'b0_000_110_000, 6'b100010, 1, 0, 0, 0);
    add("t2_c9",  10'b0_110_000_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c10", 10'b0_110_110_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c11", 10'b0_110_110_000, 6'b110000, 0, 0, 0, 0);
    add("t2_c12", 10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t2_c13", 10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    // B write held off by three stall cycles
    add("t3_c0",  10'b0_000_111_000, 6'b000000, 1, 0, 0, 0);
    add("t3_c1",  10'b0_000_111_100, 6'b110000, 1, 0, 0, 0);
    add("t3_c2",  10'b0_000_111_100, 6'b110000, 1, 0, 0, 0);
    add("t3_c3",  10'b0_000_111_100, 6'b110000, 1, 0, 0, 0);
    add("t3_c4",  10'b0_000_111_000, 6'b110000, 1, 0, 0, 0);
    add("t3_c5",  10'b0_000_111_010, 6'b100000, 1, 0, 0, 0);
    add("t3_c6",  10'b0_000_111_000, 6'b100010, 1, 0, 0, 0);
    add("t3_c7",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t3_c8",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    // A read answered with ERR
    add("t4_c0",  10'b0_110_000_000, 6'b000000, 0, 0, 0, 0);
    add("t4_c1",  10'b0_110_000_000, 6'b110000, 0, 0, 0, 0);
    add("t4_c2",  10'b0_110_000_001, 6'b100000, 0, 0, 0, 0);
    add("t4_c3",  10'b0_110_000_000, 6'b000100, 0, 0, 0, 0);
    add("t4_c4",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t4_c5",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    // A aborts with a request in flight; late ack ignored, B granted next
    add("t5_c0",  10'b0_110_000_000, 6'b000000, 0, 0, 0, 0);
    add("t5_c1",  10'b0_110_000_000, 6'b110000, 0, 0, 0, 0);
    add("t5_c2",  10'b0_000_110_010, 6'b000000, 0, 0, 0, 0);
    add("t5_c3",  10'b0_000_110_000, 6'b000000, 0, 0, 0, 0);
    add("t5_c4",  10'b0_000_110_000, 6'b110000, 1, 0, 0, 0);
    add("t5_c5",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);
    add("t5_c6",  10'b0_000_000_000, 6'b000000, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rst    = v.inb[9];
      a_cyc  = v.inb[8]; a_stb = v.inb[7]; a_we = v.inb[6];
      b_cyc  = v.inb[5]; b_stb = v.inb[4]; b_we = v.inb[3];
      mstall = v.inb[2]; mack  = v.inb[1]; merr = v.inb[0];
      mdata_in = v.md;
      #2;
      check(v.name, {58'd0, mcyc, mstb, a_ack, a_err, b_ack, b_err}, {58'd0, v.ex});
      if (v.ex[5]) begin
        if (v.own_b)
          check({v.name, "_bus"}, {mwe, maddr, mdata_out, msel},
                {v.inb[3], 12'h0AB, 32'h1234_5678, 4'hF});
        else
          check({v.name, "_bus"}, {mwe, maddr, mdata_out, msel},
                {v.inb[6], 12'h010, 32'hA5A5_A5A5, 4'h3});
      end
      if (v.chk_ad) check({v.name, "_adata"}, a_rdata, v.ad);
    end

    // Reset asserted mid-cycle while B is stalled, then a lone A request
    @(negedge clk);
    rst = 0; a_cyc = 0; a_stb = 0; b_cyc = 1; b_stb = 1; b_we = 0;
    mstall = 0; mack = 0; merr = 0;
    @(negedge clk);
    mstall = 1;
    #2;
    check("t6_stall", {mcyc, mstb}, 2'b11);
    #1;
    rst = 1;
    #1;
    check("t6_async", {mcyc, mstb, a_ack, a_err, b_ack, b_err}, 6'b000000);
    @(negedge clk);
    rst = 0; b_cyc = 0; b_stb = 0; mstall = 0;
    a_cyc = 1; a_stb = 1;
    #2;
    check("t6_idle", {mcyc, mstb}, 2'b00);
    @(negedge clk);
    #2;
    check("t6_grant_a", {mcyc, mstb, maddr}, {2'b11, 12'h010});
    @(negedge clk);
    a_cyc = 0; a_stb = 0;
    #2;
    check("t6_release", {mcyc, mstb, a_ack, b_ack}, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
